// File: rtl/av_burst_mem_if.sv
// av_burst_mem_if: bus bundle for av_burst_mem_model.
//   Slave port  : address, byteenable, write, writedata, read -> readdata, readdatavalid
//   rx port     : rx_burstcount, rx_address, rx_read -> rx_waitrequest, rx_readdata, rx_readdatavalid
//   tx port     : tx_burstcount, tx_address, tx_write, tx_writedata -> tx_waitrequest
//   wr_port     : wr_port_valid, wr_port_data, wr_port_addr
// Modports: master (bus-functional driver side), slave (memory side).
interface av_burst_mem_if;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        readdatavalid;

  logic        rx_waitrequest;
  logic [11:0] rx_burstcount;
  logic [31:0] rx_address;
  logic        rx_read;
  logic [31:0] rx_readdata;
  logic        rx_readdatavalid;

  logic        tx_waitrequest;
  logic [11:0] tx_burstcount;
  logic [31:0] tx_address;
  logic        tx_write;
  logic [31:0] tx_writedata;

  logic        wr_port_valid;
  logic [31:0] wr_port_data;
  logic [31:0] wr_port_addr;

  modport master (
    output address, byteenable, write, writedata, read,
    input  readdata, readdatavalid,
    input  rx_waitrequest, rx_readdata, rx_readdatavalid,
    output rx_burstcount, rx_address, rx_read,
    input  tx_waitrequest,
    output tx_burstcount, tx_address, tx_write, tx_writedata,
    output wr_port_valid, wr_port_data, wr_port_addr
  );

  modport slave (
    input  address, byteenable, write, writedata, read,
    output readdata, readdatavalid,
    output rx_waitrequest, rx_readdata, rx_readdatavalid,
    input  rx_burstcount, rx_address, rx_read,
    output tx_waitrequest,
    input  tx_burstcount, tx_address, tx_write, tx_writedata,
    input  wr_port_valid, wr_port_data, wr_port_addr
  );
endinterface

// File: rtl/av_burst_mem_model.sv
// av_burst_mem_model: shared 32-bit word memory with four access ports.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (memory contents retained)
//   bus   : av_burst_mem_if.slave
//     - Avalon-MM single-word slave (byte enables, RD_LATENCY-cycle read pipeline)
//     - rx burst-read port (IDLE/BURST FSM)
//     - tx burst-write port (no backpressure)
//     - wr_port direct full-word write
// Parameters: MEM_ADDR_WIDTH (log2 words), RD_LATENCY (1..4).
// Optional macro MEM_MODEL_ZERO_INIT_EN: memory starts all-zero at time zero;
// otherwise unwritten words are undefined.
module av_burst_mem_model #(
  parameter int unsigned MEM_ADDR_WIDTH = 12,
  parameter int unsigned RD_LATENCY     = 1
) (
  input logic           clk,
  input logic           rst_n,
  av_burst_mem_if.slave bus
);

  localparam int unsigned DEPTH = 1 << MEM_ADDR_WIDTH;

  typedef logic [MEM_ADDR_WIDTH-1:0] idx_t;
  typedef enum logic {RX_IDLE, RX_BURST} rx_state_t;

`ifdef MEM_MODEL_ZERO_INIT_EN
  logic [31:0] mem [0:DEPTH-1] = '{default: '0};
`else
  logic [31:0] mem [0:DEPTH-1];
`endif

  // Word indices; address bits above the memory size alias.
  idx_t s_idx, rx_start_idx, tx_start_idx, wr_idx, tx_idx;
  assign s_idx        = bus.address[MEM_ADDR_WIDTH+1:2];
  assign rx_start_idx = bus.rx_address[MEM_ADDR_WIDTH+1:2];
  assign tx_start_idx = bus.tx_address[MEM_ADDR_WIDTH+1:2];
  assign wr_idx       = bus.wr_port_addr[MEM_ADDR_WIDTH+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.address[31:MEM_ADDR_WIDTH+2],      bus.address[1:0],
                              bus.rx_address[31:MEM_ADDR_WIDTH+2],   bus.rx_address[1:0],
                              bus.tx_address[31:MEM_ADDR_WIDTH+2],   bus.tx_address[1:0],
                              bus.wr_port_addr[31:MEM_ADDR_WIDTH+2], bus.wr_port_addr[1:0]};

  // ---------------------------------------------------------------------------
  // tx burst write: remaining count of 0 marks the next beat as a first beat.
  // ---------------------------------------------------------------------------
  logic [11:0] tx_rem;
  idx_t        tx_addr_q;
  logic        tx_wait_q;
  logic        tx_first;

  assign tx_first = (tx_rem == '0);
  assign tx_idx   = tx_first ? tx_start_idx : tx_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_rem    <= '0;
      tx_addr_q <= '0;
      tx_wait_q <= 1'b1;
    end else begin
      tx_wait_q <= 1'b0;
      if (bus.tx_write) begin
        tx_addr_q <= tx_idx + 1'b1;
        if (tx_first)
          tx_rem <= (bus.tx_burstcount == '0) ? '0 : bus.tx_burstcount - 12'd1;
        else
          tx_rem <= tx_rem - 12'd1;
      end
    end
  end

  assign bus.tx_waitrequest = tx_wait_q;

  // ---------------------------------------------------------------------------
  // Memory writes. Collision priority wr_port > tx > slave falls out of the
  // order of the non-blocking updates: later assignments to the same lane win.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n) begin
      if (bus.write) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (bus.byteenable[b])
            mem[s_idx][8*b +: 8] <= bus.writedata[8*b +: 8];
        end
      end
      if (bus.tx_write)
        mem[tx_idx] <= bus.tx_writedata;
      if (bus.wr_port_valid)
        mem[wr_idx] <= bus.wr_port_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Slave read pipeline. Data stages only advance with a valid word so the
  // final stage holds the last returned word between reads.
  // ---------------------------------------------------------------------------
  logic [RD_LATENCY-1:0] rd_vld;
  logic [31:0]           rd_dat [0:RD_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++)
        rd_dat[i] <= '0;
    end else begin
      rd_vld[0] <= bus.read;
      if (bus.read)
        rd_dat[0] <= mem[s_idx];
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        if (rd_vld[i-1])
          rd_dat[i] <= rd_dat[i-1];
      end
    end
  end

  assign bus.readdata      = rd_dat[RD_LATENCY-1];
  assign bus.readdatavalid = rd_vld[RD_LATENCY-1];

  // ---------------------------------------------------------------------------
  // rx burst read FSM with registered outputs.
  // ---------------------------------------------------------------------------
  rx_state_t   rx_state;
  idx_t        rx_addr_q;
  logic [11:0] rx_rem;
  logic        rx_wait_q;
  logic        rx_vld_q;
  logic [31:0] rx_dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      rx_addr_q <= '0;
      rx_rem    <= '0;
      rx_wait_q <= 1'b1;
      rx_vld_q  <= 1'b0;
      rx_dat_q  <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_vld_q  <= 1'b0;
          rx_wait_q <= 1'b0;
          if (bus.rx_read && (bus.rx_burstcount != '0)) begin
            rx_addr_q <= rx_start_idx;
            rx_rem    <= bus.rx_burstcount;
            rx_wait_q <= 1'b1;
            rx_state  <= RX_BURST;
          end
        end
        RX_BURST: begin
          rx_dat_q  <= mem[rx_addr_q];
          rx_vld_q  <= 1'b1;
          rx_addr_q <= rx_addr_q + 1'b1;
          rx_rem    <= rx_rem - 12'd1;
          if (rx_rem == 12'd1) begin
            rx_wait_q <= 1'b0;
            rx_state  <= RX_IDLE;
          end
        end
        default: begin
          rx_state  <= RX_IDLE;
          rx_wait_q <= 1'b0;
          rx_vld_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_waitrequest   = rx_wait_q;
  assign bus.rx_readdatavalid = rx_vld_q;
  assign bus.rx_readdata      = rx_dat_q;

endmodule

// File: tb/tb_av_burst_mem_model.sv
// tb_av_burst_mem_model: directed self-checking bench for av_burst_mem_model
// (MEM_ADDR_WIDTH=12, RD_LATENCY=1).
module tb_av_burst_mem_model;

  localparam int unsigned RD_LAT = 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [5:0] exp_rx_wait;
  logic [5:0] exp_rx_vld;
  int         exp_rx_dat [6];

  av_burst_mem_if bus();

  av_burst_mem_model #(
    .MEM_ADDR_WIDTH(12),
    .RD_LATENCY    (RD_LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.address    = a;
    bus.writedata  = d;
    bus.byteenable = be;
    bus.write      = 1'b1;
    tick();
    bus.write      = 1'b0;
  endtask

  task automatic slave_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    int lat;
    bus.address = a;
    bus.read    = 1'b1;
    tick();
    bus.read    = 1'b0;
    lat = 1;
    while (!bus.readdatavalid && lat < 8) begin
      tick();
      lat++;
    end
    check_val({tag, "_lat"}, 32'(lat), 32'(RD_LAT));
    check_val(tag, bus.readdata, exp);
  endtask

  task automatic tx_beat(input logic [31:0] a, input logic [11:0] bc, input logic [31:0] d);
    bus.tx_address    = a;
    bus.tx_burstcount = bc;
    bus.tx_writedata  = d;
    bus.tx_write      = 1'b1;
    tick();
    bus.tx_write      = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.address = '0;  bus.byteenable = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
    bus.rx_burstcount = '0; bus.rx_address = '0; bus.rx_read = 1'b0;
    bus.tx_burstcount = '0; bus.tx_address = '0; bus.tx_write = 1'b0; bus.tx_writedata = '0;
    bus.wr_port_valid = 1'b0; bus.wr_port_data = '0; bus.wr_port_addr = '0;
    exp_rx_wait = 6'b001111;
    exp_rx_vld  = 6'b011110;
    exp_rx_dat  = '{0, 1, 2, 3, 4, 0};

    // Reset state
    tick();
    tick();
    check_val("rst_readdata",   bus.readdata, 32'h0);
    check_val("rst_rdvalid",    32'(bus.readdatavalid), 32'h0);
    check_val("rst_rx_data",    bus.rx_readdata, 32'h0);
    check_val("rst_rx_valid",   32'(bus.rx_readdatavalid), 32'h0);
    check_val("rst_rx_wait",    32'(bus.rx_waitrequest), 32'h1);
    check_val("rst_tx_wait",    32'(bus.tx_waitrequest), 32'h1);
    rst_n = 1'b1;
    tick();
    check_val("rel_rx_wait",    32'(bus.rx_waitrequest), 32'h0);
    check_val("rel_tx_wait",    32'(bus.tx_waitrequest), 32'h0);

    // Slave byte-enable merge and read latency
    slave_write(32'h100, 32'hDEADBEEF, 4'hF);
    slave_write(32'h100, 32'h00005500, 4'b0010);
    slave_read("be_merge", 32'h100, 32'hDEAD55EF);
    tick();
    check_val("rd_valid_drop", 32'(bus.readdatavalid), 32'h0);
    check_val("rd_hold",       bus.readdata, 32'hDEAD55EF);

    // Read and write to the same word in one cycle returns the old word
    bus.address = 32'h100; bus.writedata = 32'h0BADF00D; bus.byteenable = 4'hF;
    bus.write = 1'b1; bus.read = 1'b1;
    tick();
    bus.write = 1'b0; bus.read = 1'b0;
    check_val("rw_same_valid", 32'(bus.readdatavalid), 32'h1);
    check_val("rw_same_old",   bus.readdata, 32'hDEAD55EF);
    slave_read("rw_same_new", 32'h100, 32'h0BADF00D);

    // Back-to-back reads give back-to-back valids
    bus.address = 32'h100; bus.read = 1'b1;
    tick();
    check_val("b2b_v0", 32'(bus.readdatavalid), 32'h1);
    bus.address = 32'h104;
    tick();
    bus.read = 1'b0;
    check_val("b2b_v1", 32'(bus.readdatavalid), 32'h1);

    // Aliasing above the memory size
    slave_write(32'h0, 32'h12345678, 4'hF);
    slave_read("alias", 32'h4000, 32'h12345678);

    // tx burst with a gap between beats 2 and 3; later beats ignore address/count
    tx_beat(32'h200, 12'd4, 32'd1);
    tx_beat(32'hFF0, 12'd9, 32'd2);
    tick();
    tx_beat(32'hFF0, 12'd9, 32'd3);
    tx_beat(32'hFF0, 12'd9, 32'd4);
    slave_read("tx_w0", 32'h200, 32'd1);
    slave_read("tx_w1", 32'h204, 32'd2);
    slave_read("tx_w2", 32'h208, 32'd3);
    slave_read("tx_w3", 32'h20C, 32'd4);

    // tx burst wrapping past the top of memory
    tx_beat(32'h3FFC, 12'd2, 32'h77);
    tx_beat(32'h0,    12'd0, 32'h88);
    slave_read("tx_wrap_top", 32'h3FFC, 32'h77);
    slave_read("tx_wrap_low", 32'h0,    32'h88);

    // rx burst of 4 at 0x200
    bus.rx_address = 32'h200; bus.rx_burstcount = 12'd4; bus.rx_read = 1'b1;
    check_val("rx_idle_wait", 32'(bus.rx_waitrequest), 32'h0);
    tick();
    bus.rx_read = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check_val($sformatf("rx_wait_c%0d", c),  32'(bus.rx_waitrequest),   32'(exp_rx_wait[c]));
      check_val($sformatf("rx_valid_c%0d", c), 32'(bus.rx_readdatavalid), 32'(exp_rx_vld[c]));
      if (exp_rx_vld[c])
        check_val($sformatf("rx_data_c%0d", c), bus.rx_readdata, 32'(exp_rx_dat[c]));
      tick();
    end

    // rx burstcount 0 is ignored
    bus.rx_burstcount = 12'd0; bus.rx_read = 1'b1;
    tick();
    bus.rx_read = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_val($sformatf("rx0_wait_c%0d", c),  32'(bus.rx_waitrequest),   32'h0);
      check_val($sformatf("rx0_valid_c%0d", c), 32'(bus.rx_readdatavalid), 32'h0);
      tick();
    end

    // Same-word collision: wr_port wins over tx and slave
    bus.wr_port_addr = 32'h300; bus.wr_port_data = 32'hAAAAAAAA; bus.wr_port_valid = 1'b1;
    bus.tx_address = 32'h300; bus.tx_burstcount = 12'd1; bus.tx_writedata = 32'hBBBBBBBB; bus.tx_write = 1'b1;
    bus.address = 32'h300; bus.writedata = 32'hCCCCCCCC; bus.byteenable = 4'hF; bus.write = 1'b1;
    tick();
    bus.wr_port_valid = 1'b0; bus.tx_write = 1'b0; bus.write = 1'b0;
    slave_read("coll_wr_port", 32'h300, 32'hAAAAAAAA);

    // tx (count 0 = single beat) over partial slave lanes; wr_port to another word
    bus.wr_port_addr = 32'h310; bus.wr_port_data = 32'h11111111; bus.wr_port_valid = 1'b1;
    bus.tx_address = 32'h304; bus.tx_burstcount = 12'd0; bus.tx_writedata = 32'hBBBBBBBB; bus.tx_write = 1'b1;
    bus.address = 32'h304; bus.writedata = 32'hCCCCCCCC; bus.byteenable = 4'b0101; bus.write = 1'b1;
    tick();
    bus.wr_port_valid = 1'b0; bus.tx_write = 1'b0; bus.write = 1'b0;
    slave_read("coll_tx_slave", 32'h304, 32'hBBBBBBBB);
    slave_read("coll_other",    32'h310, 32'h11111111);
    tx_beat(32'h320, 12'd1, 32'd5);
    slave_read("tx_cnt0_single", 32'h320, 32'd5);

    // Reset in the middle of an rx burst
    bus.rx_address = 32'h200; bus.rx_burstcount = 12'd4; bus.rx_read = 1'b1;
    tick();
    bus.rx_read = 1'b0;
    tick();
    check_val("mid_valid_pre", 32'(bus.rx_readdatavalid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(bus.rx_readdatavalid), 32'h0);
    check_val("mid_rst_wait",  32'(bus.rx_waitrequest),   32'h1);
    check_val("mid_rst_txw",   32'(bus.tx_waitrequest),   32'h1);
    slave_write(32'h200, 32'h99, 4'hF);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("post_rx_wait",  32'(bus.rx_waitrequest),   32'h0);
    check_val("post_tx_wait",  32'(bus.tx_waitrequest),   32'h0);
    check_val("post_rx_valid", 32'(bus.rx_readdatavalid), 32'h0);
    slave_read("post_keep200", 32'h200, 32'd1);
    slave_read("post_keep100", 32'h100, 32'h0BADF00D);

`ifdef MEM_MODEL_ZERO_INIT_EN
    slave_read("zero_init", 32'h400, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/av_burst_mem_model.md
Name: av_burst_mem_model

Overview:
- Behavioural and synthesizable word memory with four access ports on one clock:
  - an Avalon-MM single-word slave port (byte enables, pipelined read with readdatavalid);
  - an Avalon burst-read port (rx);
  - an Avalon burst-write port (tx);
  - a direct write-only port (wr_port).
- Serves as the target memory behind a bus-functional master in block-level benches.
- All ports share one storage array.

Parameters:
- MEM_ADDR_WIDTH, 12: log2 of the number of 32-bit words (default 4096 words).
- RD_LATENCY, 1: slave-port cycles from read command to readdatavalid. Legal values are 1 to 4.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- address  in  32  slave byte address; word index = address[MEM_ADDR_WIDTH+1:2].
- byteenable  in  4  slave write byte lanes; bit n enables writedata[8n+7:8n].
- write  in  1  slave write strobe.
- writedata  in  32  slave write data.
- read  in  1  slave read strobe.
- readdata  out  32  slave read data.
- readdatavalid  out  1  slave read data valid.
- rx_waitrequest  out  1  burst-read port busy.
- rx_burstcount  in  12  burst-read length in words.
- rx_address  in  32  burst-read start byte address.
- rx_read  in  1  burst-read command.
- rx_readdata  out  32  burst-read data.
- rx_readdatavalid  out  1  burst-read data valid.
- tx_waitrequest  out  1  burst-write port stall.
- tx_burstcount  in  12  burst-write length, sampled on the first beat.
- tx_address  in  32  burst-write start byte address, sampled on the first beat.
- tx_write  in  1  burst-write beat strobe.
- tx_writedata  in  32  burst-write beat data.
- wr_port_valid  in  1  direct write strobe.
- wr_port_data  in  32  direct write data.
- wr_port_addr  in  32  direct write byte address.

Behaviour:
- Addressing:
  - All byte addresses drop bits [1:0].
  - Bits above MEM_ADDR_WIDTH+1 are ignored, so accesses alias and wrap modulo the memory size.
  - Burst address increments by 1 word per beat and wraps at the top of memory.
- Reset (rst_n=0, asynchronous):
  - readdata, rx_readdata = 0; readdatavalid, rx_readdatavalid = 0.
  - rx_waitrequest = 1 and tx_waitrequest = 1.
  - Active bursts and the read pipeline are discarded.
  - Memory contents are retained; all writes are ignored while in reset.
- Slave port:
  - No waitrequest; every command is accepted in the cycle it is asserted.
  - write: enabled byte lanes update at the clock edge.
  - read: readdata is driven with the word and readdatavalid pulses high exactly RD_LATENCY cycles later. Back-to-back reads give back-to-back valids. readdata holds its last value when not valid.
  - read and write in the same cycle: the write is performed and the read returns the pre-write word.
- rx burst read:
  - States: IDLE (rx_waitrequest=0) and BURST (rx_waitrequest=1).
  - In IDLE, rx_read with rx_burstcount=N>0 latches the address and N and moves to BURST.
  - In BURST, one word is returned per cycle starting the cycle after acceptance, with rx_readdatavalid=1 for exactly N consecutive cycles.
  - After the N-th word the block returns to IDLE; a new command may be accepted in that same cycle.
  - N=0 is accepted and ignored: no data, stays in IDLE.
  - rx_read is ignored while in BURST.
  - Each word reflects memory at the edge it is read, so writes landing mid-burst are visible.
- tx burst write:
  - tx_waitrequest=0 whenever out of reset; there is no backpressure.
  - A tx_write beat while the remaining count is 0 is a first beat: it latches tx_address and tx_burstcount (0 is treated as 1) and writes the word to the start address.
  - Each subsequent tx_write beat writes the next word and decrements the remaining count.
  - Cycles without tx_write insert no beat.
  - All byte lanes are written.
- wr_port: wr_port_valid writes the full word at wr_port_addr in that cycle.
- Same-word write collision in one cycle: priority is wr_port > tx > slave, applied per byte lane. Writes to different words all take effect.

Optional Feature:
- MEM_MODEL_ZERO_INIT_EN:
  - Defined: every memory word is 0 at time zero, so reads of unwritten locations return 32'h0.
  - Undefined: there is no initialisation; unwritten locations are undefined (X in simulation).
- Reset never clears memory in either case.

Test Plan:
- Reset: assert rst_n=0 mid-rx-burst → rx_readdatavalid drops to 0 immediately and rx_waitrequest=1. After release rx_waitrequest=0, tx_waitrequest=0, and previously written data is intact.
- Slave write 0x100=0xDEADBEEF with byteenable=4'hF, then byteenable=4'b0010 with data 0x00005500 → read 0x100 returns 0xDEAD55EF with readdatavalid one cycle after read (RD_LATENCY=1).
- Aliasing: write 0x0 with 0x12345678, then read 0x4000 (MEM_ADDR_WIDTH=12) → returns 0x12345678.
- tx burst: address 0x200, burstcount 4, data 1..4 with a gap cycle between beats 2 and 3 → slave reads 0x200..0x20C return 1,2,3,4.
- rx burst: address 0x200, burstcount 4 → rx_waitrequest high 4 cycles and rx_readdatavalid high 4 consecutive cycles with data 1,2,3,4; burstcount 0 → no valid and rx_waitrequest stays 0.
- Collision: wr_port 0x300=0xAAAAAAAA, tx beat 0x300=0xBBBBBBBB and slave write 0x300=0xCCCCCCCC in the same cycle → read 0x300 returns 0xAAAAAAAA. With MEM_MODEL_ZERO_INIT_EN defined, a read of unwritten 0x400 returns 0.
